sprite_path_ctrl: RTL

- Parametrised sprite motion controller that produces sprite centre and size for the VGA colour mapper, advancing once per frame.
- Supports three motion sources: manual WASD steering (latched or hold-to-move), an automatic closed octagonal orbit triggered by Space, and a return-to-centre on Esc.
- Enforces screen bounds with a selectable policy: respawn at centre with a hold-off period, or clamp at the edge.

---
 rtl/sprite_path_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_path_ctrl.sv
// Per-frame sprite motion controller: manual WASD steering, an octagonal orbit on
// Space, return-to-centre on Esc, and screen-bound enforcement by respawn or clamp.
module sprite_path_ctrl #(
  parameter int W              = 10,
  parameter int X_CENTER       = 335,
  parameter int Y_CENTER       = 200,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 479,
  parameter int SIZE           = 8,
  parameter int MAN_STEP       = 1,
  parameter int ORB_STEP       = 3,
  parameter int SEG_FRAMES     = 10,
  parameter int LATCH          = 1,
  parameter int BOUND_MODE     = 0,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic         Reset,
  input  logic         frame_clk,
  input  logic [7:0]   keycode,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic [1:0]   mode,
  output logic [2:0]   seg,
  output logic         respawn_active,
  output logic         bound_hit
);

  typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1, ORBIT = 2'd2, RESPAWN = 2'd3} state_t;
  typedef logic signed [W+1:0] sc_t;

  localparam sc_t SZ   = sc_t'(SIZE);
  localparam sc_t XMIN = sc_t'(X_MIN);
  localparam sc_t XMAX = sc_t'(X_MAX);
  localparam sc_t YMIN = sc_t'(Y_MIN);
  localparam sc_t YMAX = sc_t'(Y_MAX);
  localparam sc_t MS   = sc_t'(MAN_STEP);
  localparam sc_t OS   = sc_t'(ORB_STEP);

  state_t      state_reg, state_next;
  logic [W-1:0] x_reg, x_next, y_reg, y_next;
  logic [2:0]  seg_reg, seg_next;
  logic [7:0]  frame_reg, frame_next, hold_reg, hold_next;
  sc_t         mdx_reg, mdx_next, mdy_reg, mdy_next;
  logic        hit_reg, hit_next;

  logic key_wasd, key_space, key_esc;
  sc_t  kdx, kdy, odx, ody, dx, dy, nx, ny;
  logic viol;

  always_comb begin
    key_wasd  = 1'b0;
    key_space = 1'b0;
    key_esc   = 1'b0;
    kdx       = '0;
    kdy       = '0;
    case (keycode)
      8'h04: begin key_wasd = 1'b1; kdx = -MS; end
      8'h07: begin key_wasd = 1'b1; kdx = MS;  end
      8'h16: begin key_wasd = 1'b1; kdy = MS;  end
      8'h1A: begin key_wasd = 1'b1; kdy = -MS; end
      8'h2C: key_space = 1'b1;
      8'h29: key_esc   = 1'b1;
      default: ;
    endcase
  end

  // Orbit heading per segment; eight 45-degree legs close the loop.
  always_comb begin
    odx = '0;
    ody = '0;
    case (seg_reg)
      3'd0: odx = -OS;
      3'd1: begin odx = -OS; ody = OS;  end
      3'd2: ody = OS;
      3'd3: begin odx = OS;  ody = OS;  end
      3'd4: odx = OS;
      3'd5: begin odx = OS;  ody = -OS; end
      3'd6: ody = -OS;
      default: begin odx = -OS; ody = -OS; end
    endcase
  end

  always_comb begin
    dx = '0;
    dy = '0;
    case (state_reg)
      IDLE: begin
        if (key_esc) begin
        end else if (key_wasd) begin
          dx = kdx; dy = kdy;
        end else if (key_space) begin
          dx = -OS;
        end
      end
      MANUAL: begin
        if (key_esc) begin
        end else if (key_wasd) begin
          dx = kdx; dy = kdy;
        end else if (key_space) begin
          dx = -OS;
        end else if (LATCH != 0) begin
          dx = mdx_reg; dy = mdy_reg;
        end
      end
      ORBIT: begin
        if (key_esc) begin
        end else if (key_wasd) begin
          dx = kdx; dy = kdy;
        end else begin
          dx = odx; dy = ody;
        end
      end
      default: ;
    endcase
    nx   = $signed({2'b00, x_reg}) + dx;
    ny   = $signed({2'b00, y_reg}) + dy;
    viol = (state_reg != RESPAWN) &&
           ((nx - SZ) < XMIN || (nx + SZ) > XMAX || (ny - SZ) < YMIN || (ny + SZ) > YMAX);
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    seg_next   = seg_reg;
    frame_next = frame_reg;
    hold_next  = hold_reg;
    mdx_next   = mdx_reg;
    mdy_next   = mdy_reg;
    hit_next   = 1'b0;
    if (state_reg == RESPAWN) begin
      if (hold_reg == 8'(RESPAWN_FRAMES - 1)) begin
        state_next = IDLE;
        hold_next  = '0;
      end else begin
        hold_next = hold_reg + 8'd1;
      end
    end else if (viol) begin
      hit_next = 1'b1;
      mdx_next = '0;
      mdy_next = '0;
      if (BOUND_MODE == 0) begin
        x_next     = W'(X_CENTER);
        y_next     = W'(Y_CENTER);
        state_next = RESPAWN;
        hold_next  = '0;
      end else if (state_reg == ORBIT) begin
        state_next = MANUAL;
      end
    end else if (key_esc) begin
      x_next     = W'(X_CENTER);
      y_next     = W'(Y_CENTER);
      mdx_next   = '0;
      mdy_next   = '0;
      state_next = IDLE;
    end else if (key_wasd) begin
      x_next     = nx[W-1:0];
      y_next     = ny[W-1:0];
      mdx_next   = kdx;
      mdy_next   = kdy;
      state_next = MANUAL;
    end else if (key_space && state_reg != ORBIT) begin
      x_next     = nx[W-1:0];
      y_next     = ny[W-1:0];
      mdx_next   = '0;
      mdy_next   = '0;
      state_next = ORBIT;
      // The entry edge already moved the sprite, so it counts as frame 0 of segment 0.
      if (SEG_FRAMES == 1) begin
        seg_next   = 3'd1;
        frame_next = '0;
      end else begin
        seg_next   = 3'd0;
        frame_next = 8'd1;
      end
    end else begin
      x_next = nx[W-1:0];
      y_next = ny[W-1:0];
      if (state_reg == ORBIT) begin
        if (frame_reg == 8'(SEG_FRAMES - 1)) begin
          frame_next = '0;
          seg_next   = seg_reg + 3'd1;
        end else begin
          frame_next = frame_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      x_reg     <= W'(X_CENTER);
      y_reg     <= W'(Y_CENTER);
      seg_reg   <= '0;
      frame_reg <= '0;
      hold_reg  <= '0;
      mdx_reg   <= '0;
      mdy_reg   <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      seg_reg   <= seg_next;
      frame_reg <= frame_next;
      hold_reg  <= hold_next;
      mdx_reg   <= mdx_next;
      mdy_reg   <= mdy_next;
      hit_reg   <= hit_next;
    end
  end

  assign BallX          = x_reg;
  assign BallY          = y_reg;
  assign BallS          = W'(SIZE);
  assign mode           = state_reg;
  assign seg            = seg_reg;
  assign respawn_active = (state_reg == RESPAWN);
  assign bound_hit      = hit_reg;

endmodule
